// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM state encoding and the
// funct-style op codes the ALU understands.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_OR  = 6'b100101;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes to
// the requester that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = 2'b00;
    if (req[0] && (!req[1] || last_grant)) gnt = 2'b01;
    else if (req[1])                       gnt = 2'b10;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with
// round-robin arbitration. Define ALU_SHARE_OPCHECK_EN to add the resp_err port.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 6,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_d1,
  input  logic [2*DATA_W-1:0] req_d2,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_zero,
`ifdef ALU_SHARE_OPCHECK_EN
  output logic                resp_err,
`endif
  output logic [DATA_W-1:0]   alu_d1,
  output logic [DATA_W-1:0]   alu_d2,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  output logic                busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t              state;
  logic                last_grant;
  logic                grant_id;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   d1_q;
  logic [DATA_W-1:0]   d2_q;
  logic [OP_W-1:0]     op_q;
  logic [1:0]          gnt;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Requesters only see ready while idle; the arbiter output is one-hot.
  assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;

  // The ALU only ever sees captured operands, never the live request buses.
  assign alu_d1 = d1_q;
  assign alu_d2 = d2_q;
  assign alu_op = op_q;

  // NOTE: sequential state uses non-blocking assignments, and every register
  // clears on the async reset so an in-flight result is dropped immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      op_q       <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_valid <= 2'b00;
      busy       <= 1'b0;
`ifdef ALU_SHARE_OPCHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            d1_q     <= gnt[1] ? req_d1[DATA_W +: DATA_W] : req_d1[0 +: DATA_W];
            d2_q     <= gnt[1] ? req_d2[DATA_W +: DATA_W] : req_d2[0 +: DATA_W];
            op_q     <= gnt[1] ? req_op[OP_W +: OP_W]     : req_op[0 +: OP_W];
            grant_id <= gnt[1];
            cnt      <= CNT_INIT;
            busy     <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_data  <= alu_out;
            resp_zero  <= alu_zero;
            resp_valid <= grant_id ? 2'b10 : 2'b01;
`ifdef ALU_SHARE_OPCHECK_EN
            resp_err   <= !((op_q == OP_W'(OP_ADD)) || (op_q == OP_W'(OP_SUB)) ||
                            (op_q == OP_W'(OP_OR)));
`endif
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready[grant_id]) begin
            last_grant <= grant_id;
            resp_valid <= 2'b00;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter against a transaction-level model of
// grants, latency and results; honours ALU_SHARE_OPCHECK_EN.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int OW = 6;
  localparam int EC = 3;

  typedef enum {M_OFF, M_TABLE, M_R0, M_R1, M_BOTH, M_RAND} mode_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, resp_valid, resp_ready;
  logic [2*DW-1:0]   req_d1, req_d2;
  logic [2*OW-1:0]   req_op;
  logic [DW-1:0]     resp_data, alu_d1, alu_d2, alu_out;
  logic [OW-1:0]     alu_op;
  logic              resp_zero, alu_zero, busy;
`ifdef ALU_SHARE_OPCHECK_EN
  logic              resp_err;
`endif

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW), .EXEC_CYCLES(EC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_d1     (req_d1),
    .req_d2     (req_d2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_zero  (resp_zero),
`ifdef ALU_SHARE_OPCHECK_EN
    .resp_err   (resp_err),
`endif
    .alu_d1     (alu_d1),
    .alu_d2     (alu_d2),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    if (op == OP_ADD) return a + b;
    if (op == OP_SUB) return a - b;
    if (op == OP_OR)  return a | b;
    return '0;
  endfunction

  // The shared ALU itself.
  always_comb begin
    alu_out  = alu_fn(alu_d1, alu_d2, alu_op);
    alu_zero = (alu_out == '0);
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus ----------------
  mode_t      mode = M_OFF;
  logic [1:0] took = 2'b00;
  int         tbl_n[2] = '{0, 0};
  bit         log_en = 0;

  task automatic new_payload(input int i);
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    int r;
    if (mode == M_TABLE && tbl_n[i] < 2) begin
      if (i == 0) begin
        a  = (tbl_n[i] == 0) ? 32'd1 : 32'd9;
        b  = (tbl_n[i] == 0) ? 32'd1 : 32'd4;
        op = (tbl_n[i] == 0) ? OP_ADD : OP_SUB;
      end else begin
        a  = (tbl_n[i] == 0) ? 32'hF0 : 32'd2;
        b  = (tbl_n[i] == 0) ? 32'h0F : 32'd2;
        op = (tbl_n[i] == 0) ? OP_OR : OP_ADD;
      end
      tbl_n[i]++;
    end else begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      r = $urandom_range(0, 7);
      case (r)
        0, 1:    op = OP_ADD;
        2, 3:    op = OP_SUB;
        4, 5:    op = OP_OR;
        6:       op = OW'($urandom);
        default: op = '0;
      endcase
    end
    req_d1[i*DW +: DW] = a;
    req_d2[i*DW +: DW] = b;
    req_op[i*OW +: OW] = op;
  endtask

  task automatic drive_cycle();
    for (int i = 0; i < 2; i++) begin
      if ((mode == M_R0 && i == 1) || (mode == M_R1 && i == 0)) begin
        req_valid[i] = 1'b0;
      end else if (!req_valid[i] || took[i]) begin
        if (mode == M_RAND && $urandom_range(0, 2) == 0) req_valid[i] = 1'b0;
        else begin
          req_valid[i] = 1'b1;
          new_payload(i);
        end
      end else if (mode == M_RAND && $urandom_range(0, 9) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    resp_ready = (mode == M_RAND) ? 2'($urandom_range(0, 3)) : 2'b11;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode != M_OFF) drive_cycle();
    end
  end

  // ---------------- reference model ----------------
  bit            m_free = 1;
  bit            m_last = 1;
  bit            m_id;
  int            m_due;
  logic [DW-1:0] m_d1, m_d2, m_res;
  logic [OW-1:0] m_op;
  int            n_done = 0;
  logic          gnt_log[$];
  logic [DW-1:0] res_log[$];

  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    took = 2'b00;
    if (!rst_n) begin
      m_free = 1;
      m_last = 1;
    end else if (m_free) begin
      if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      else                    exp_rdy = req_valid;
      check("req_ready_idle", req_ready, exp_rdy);
      check("busy_idle", busy, 1'b0);
      check("resp_valid_idle", resp_valid, 2'b00);
      if (log_en && (req_ready & req_valid) != 2'b00) gnt_log.push_back(req_ready[1]);
      if (exp_rdy != 2'b00) begin
        m_id   = exp_rdy[1];
        m_d1   = req_d1[m_id*DW +: DW];
        m_d2   = req_d2[m_id*DW +: DW];
        m_op   = req_op[m_id*OW +: OW];
        m_res  = alu_fn(m_d1, m_d2, m_op);
        m_due  = cyc + EC + 1;
        m_free = 0;
        took   = exp_rdy;
      end
    end else begin
      check("req_ready_busy", req_ready, 2'b00);
      check("busy", busy, 1'b1);
      check("alu_d1", alu_d1, m_d1);
      check("alu_d2", alu_d2, m_d2);
      check("alu_op", alu_op, m_op);
      if (cyc < m_due) begin
        check("resp_valid_early", resp_valid, 2'b00);
      end else begin
        check("resp_valid", resp_valid, m_id ? 2'b10 : 2'b01);
        check("resp_data", resp_data, m_res);
        check("resp_zero", resp_zero, m_res == '0);
`ifdef ALU_SHARE_OPCHECK_EN
        check("resp_err", resp_err, !(m_op == OP_ADD || m_op == OP_SUB || m_op == OP_OR));
`endif
        if (resp_ready[m_id]) begin
          if (log_en) res_log.push_back(resp_data);
          m_free = 1;
          m_last = m_id;
          n_done++;
        end
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_resp_valid"}, resp_valid, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_resp_data"}, resp_data, '0);
    check({tag, "_resp_zero"}, resp_zero, 1'b0);
    check({tag, "_alu_d1"}, alu_d1, '0);
    check({tag, "_alu_d2"}, alu_d2, '0);
    check({tag, "_alu_op"}, alu_op, '0);
`ifdef ALU_SHARE_OPCHECK_EN
    check({tag, "_resp_err"}, resp_err, 1'b0);
`endif
  endtask

  initial begin
    logic exp_g[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] exp_r[4] = '{32'd2, 32'hFF, 32'd5, 32'd4};
    bit found;

    req_valid = 2'b00; resp_ready = 2'b00;
    req_d1 = '0; req_d2 = '0; req_op = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Both requesters valid from reset with fixed ops: grants 0,1,0,1.
    log_en = 1;
    mode = M_TABLE;
    repeat (4 * (EC + 2) + 4) @(posedge clk);
    #3 log_en = 0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("table_grant%0d", k), (k < gnt_log.size()) ? gnt_log[k] : 1'bx, exp_g[k]);
      check($sformatf("table_result%0d", k), (k < res_log.size()) ? res_log[k] : 'x, exp_r[k]);
    end

    mode = M_R0;   repeat (30) @(posedge clk);
    mode = M_R1;   repeat (30) @(posedge clk);
    mode = M_BOTH; repeat (60) @(posedge clk);
    mode = M_RAND; repeat (600) @(posedge clk);

    // Reset while a transaction is executing.
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #3 if (!m_free && cyc < m_due) found = 1;
    end
    check("exec_found", found, 1'b1);
    mode = M_OFF;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    mode = M_R1;   repeat (30) @(posedge clk);
    mode = M_RAND; repeat (500) @(posedge clk);

    // Drain: stop requesting and let the last response complete.
    #3 mode = M_OFF;
    req_valid = 2'b00;
    resp_ready = 2'b11;
    for (int k = 0; k < 100 && !m_free; k++) @(posedge clk);
    @(negedge clk);
    check("drain_idle", m_free, 1'b1);
    check("traffic", n_done > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
